mult_div_unit: RTL and testbench
================================

# mult_div_unit

Iterative multiply/divide unit with architectural HI/LO registers for the MIPS datapath. Sits directly downstream of the ALU source mux: it takes operand A from the register file and operand B from the ALU source-select mux output, and executes MULT, MULTU, DIV, DIVU, MTHI and MTLO. The result stays in HI/LO until read by MFHI/MFLO. The control unit stalls the pipeline on `busy`.

## Interface
- `WIDTH`, 32, operand width; HI/LO are each `WIDTH` bits.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  op request; sampled only when `busy`=0.
- `op`  in  3  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6–7 reserved, treated as no-op.
- `a`  in  WIDTH  operand A (rs): multiplicand, dividend, or MTHI/MTLO source.
- `b`  in  WIDTH  operand B (ALU source mux output): multiplier or divisor.
- `flush`  in  1  synchronous abort of any in-flight op.
- `hi`  out  WIDTH  HI register; reset 0.
- `lo`  out  WIDTH  LO register; reset 0.
- `busy`  out  1  iteration in progress; reset 0.
- `done`  out  1  one-cycle pulse when HI/LO are updated; reset 0.
- `div_zero`  out  1  one-cycle pulse with `done` when a divide had `b`=0; reset 0.

## Operation
- FSM states: IDLE, CALC, FIX. Reset sends the FSM to IDLE and clears the iteration counter, internal 64-bit accumulator, `hi`, `lo` and all flags.
- IDLE, `start`=1, op MULT/MULTU/DIV/DIVU:
  - latch |a|, |b| (signed ops) or raw a, b (unsigned ops), plus the result signs;
  - counter = 0; go to CALC; `busy`=1.
- IDLE, `start`=1, MTHI/MTLO: write `a` to `hi` or `lo` at that edge; `done`=1 next cycle; `busy` stays 0.
- IDLE, `start`=1, op 6–7: ignored; no `done`.
- CALC: one radix-2 step per cycle for 32 cycles, then go to FIX.
  - Multiply: shift-add.
  - Divide: restoring shift-subtract.
- FIX: apply signs, write HI/LO, pulse `done`, clear `busy`, return to IDLE.
- Multiply result: full 64-bit product, HI = upper 32 bits, LO = lower 32 bits. Signed product is two's-complement.
- Divide result: LO = quotient, HI = remainder.
  - Signed quotient sign = sign(a) XOR sign(b); remainder sign = sign(a). Quotient truncates toward zero.
  - Divide by zero: LO = 0xFFFFFFFF, HI = a. `div_zero` pulses with `done`. This holds for both signed and unsigned divides.
  - DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0 (wraps, no trap).
- `start` while `busy`=1: ignored. It is not queued.
- `flush`: in any state returns to IDLE at the next edge.
  - Clears `busy`; no `done` is issued.
  - HI/LO keep their pre-op values.
  - `flush` has priority over a simultaneous `start` or FIX.
- `rst_n` low during CALC/FIX: op abandoned; all outputs go to their reset values immediately.

## Timing
- Call the edge that samples `start` E0.
- Mult/div:
  - `busy`=1 after E0 through E33;
  - CALC covers edges E1–E32; FIX occurs at E33;
  - new `hi`/`lo`, `done`=1 and `busy`=0 are visible after E33;
  - latency 33 cycles; back-to-back `start` is accepted at E34.
- MTHI/MTLO: `hi`/`lo` updated after E0, `done`=1 for the cycle after E0. A new `start` is accepted the next cycle.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- `MDU_DIV_EN` defined: full behaviour as specified above.
- `MDU_DIV_EN` undefined: divider datapath is not compiled.
  - DIV/DIVU are treated as no-ops: no `busy`, no `done`, HI/LO unchanged.
  - `div_zero` is tied to 0.
  - MULT/MULTU/MTHI/MTLO are unaffected.

## Structure
- Shared package `mips_pkg`:
  - op encodings `MDU_OP_MULT`..`MDU_OP_MTLO`;
  - FSM state typedef `mdu_state_t`;
  - constant `MDU_ITER = 32`.
- One sub-module, `mdu_shift_core`: the 64-bit accumulator with one shift-add / shift-subtract step per enable. It is sign-agnostic; the top level handles operand abs, sign fix, HI/LO and the FSM.

## Test plan
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> after 33 cycles HI=0xFFFFFFFE, LO=0x00000001, `done` pulses once.
- MULT a=0xFFFFFFFD (-3), b=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- DIV a=-7 (0xFFFFFFF9), b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU a=100, b=0 -> LO=0xFFFFFFFF, HI=100, `div_zero`=1.
- MTHI a=0x12345678 -> `hi`=0x12345678 next cycle, `busy` stays 0. A `start` issued at cycle 5 of a MULT is ignored.
- MULT started, `flush` at cycle 10 -> `busy`=0 next cycle, no `done`, HI/LO unchanged. Repeat with `rst_n` pulsed low -> HI=LO=0 immediately.
- Build without `MDU_DIV_EN`: DIV a=10, b=3 -> no `busy`, no `done`, HI/LO unchanged.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS definitions: multiply/divide op codes,
// MDU FSM state type and iteration count.
package mips_pkg;

  localparam int MDU_ITER = 32;

  localparam logic [2:0] MDU_OP_MULT  = 3'd0;
  localparam logic [2:0] MDU_OP_MULTU = 3'd1;
  localparam logic [2:0] MDU_OP_DIV   = 3'd2;
  localparam logic [2:0] MDU_OP_DIVU  = 3'd3;
  localparam logic [2:0] MDU_OP_MTHI  = 3'd4;
  localparam logic [2:0] MDU_OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    MDU_IDLE,
    MDU_CALC,
    MDU_FIX
  } mdu_state_t;

endpackage

// File: rtl/mdu_shift_core.sv
// Sign-agnostic 2*WIDTH accumulator: one shift-add or
// restoring shift-subtract step per enable (MDU_DIV_EN adds divide).
module mdu_shift_core #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               step,
  input  logic               div,
  input  logic [WIDTH-1:0]   opa,
  input  logic [WIDTH-1:0]   opb,
  output logic [2*WIDTH-1:0] acc
);

  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_d;
  logic [WIDTH-1:0]   opnd_q;
  logic [WIDTH-1:0]   addend;
  logic [WIDTH:0]     sum;

`ifdef MDU_DIV_EN
  logic               div_q;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH+1:0]   diff;
`else
  logic               unused_div;
  assign unused_div = div;
`endif

  // Next accumulator value for one iteration
  always_comb begin
    addend = acc_q[0] ? opnd_q : {WIDTH{1'b0}};
    sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    acc_d  = {sum, acc_q[WIDTH-1:1]};
`ifdef MDU_DIV_EN
    rem_sh = acc_q[2*WIDTH-1:WIDTH-1];
    diff   = {1'b0, rem_sh} - {2'b00, opnd_q};
    if (div_q) begin
      if (diff[WIDTH+1])
        acc_d = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      else
        acc_d = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end
`endif
  end

  // Load operands or advance one step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      opnd_q <= '0;
`ifdef MDU_DIV_EN
      div_q  <= 1'b0;
`endif
    end else if (load) begin
      acc_q  <= {{WIDTH{1'b0}}, opa};
      opnd_q <= opb;
`ifdef MDU_DIV_EN
      div_q  <= div;
`endif
    end else if (step) begin
      acc_q  <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MIPS multiply/divide unit with HI/LO registers.
// Define MDU_DIV_EN to build the DIV/DIVU datapath.
module mult_div_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  mdu_state_t state_q;
  mdu_state_t state_d;

  logic [5:0]         cnt_q;
  logic               neg_q;
  logic               done_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;

  logic mul_op;
  logic div_op;
  logic sgn_op;
  logic go;
  logic load;
  logic step;

  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;

`ifdef MDU_DIV_EN
  logic             is_div_q;
  logic             rneg_q;
  logic             dz_q;
  logic             dz_out_q;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
`endif

  assign mul_op = (op == MDU_OP_MULT) || (op == MDU_OP_MULTU);
`ifdef MDU_DIV_EN
  assign div_op = (op == MDU_OP_DIV) || (op == MDU_OP_DIVU);
`else
  assign div_op = 1'b0;
`endif
  assign sgn_op = (op == MDU_OP_MULT) || (op == MDU_OP_DIV);
  assign go     = start && (mul_op || div_op);
  assign abs_a  = (sgn_op && a[WIDTH-1]) ? -a : a;
  assign abs_b  = (sgn_op && b[WIDTH-1]) ? -b : b;
  assign load   = (state_q == MDU_IDLE) && go && !flush;
  assign step   = (state_q == MDU_CALC) && !flush;

  mdu_shift_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .step  (step),
    .div   (div_op),
    .opa   (abs_a),
    .opb   (abs_b),
    .acc   (acc)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= MDU_IDLE;
    else        state_q <= state_d;
  end

  // Next state and busy decode; flush wins over everything
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    unique case (state_q)
      MDU_IDLE: if (go) state_d = MDU_CALC;
      MDU_CALC: begin
        busy = 1'b1;
        if (cnt_q == 6'(MDU_ITER - 1)) state_d = MDU_FIX;
      end
      MDU_FIX: begin
        busy    = 1'b1;
        state_d = MDU_IDLE;
      end
      default: state_d = MDU_IDLE;
    endcase
    if (flush) state_d = MDU_IDLE;
  end

  // Sign fix-up of the unsigned accumulator result
  always_comb begin
    prod   = neg_q ? -acc : acc;
    res_hi = prod[2*WIDTH-1:WIDTH];
    res_lo = prod[WIDTH-1:0];
`ifdef MDU_DIV_EN
    quo = acc[WIDTH-1:0];
    rem = acc[2*WIDTH-1:WIDTH];
    if (is_div_q) begin
      res_lo = dz_q ? {WIDTH{1'b1}} : (neg_q ? -quo : quo);
      res_hi = rneg_q ? -rem : rem;
    end
`endif
  end

  // Counter, op flags, HI/LO and completion pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
`ifdef MDU_DIV_EN
      is_div_q <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
      dz_out_q <= 1'b0;
`endif
    end else begin
      done_q   <= 1'b0;
`ifdef MDU_DIV_EN
      dz_out_q <= 1'b0;
`endif
      if (!flush) begin
        unique case (state_q)
          MDU_IDLE: begin
            if (start && op == MDU_OP_MTHI) begin
              hi_q   <= a;
              done_q <= 1'b1;
            end else if (start && op == MDU_OP_MTLO) begin
              lo_q   <= a;
              done_q <= 1'b1;
            end else if (go) begin
              cnt_q    <= '0;
              neg_q    <= sgn_op && (a[WIDTH-1] ^ b[WIDTH-1]);
`ifdef MDU_DIV_EN
              is_div_q <= div_op;
              rneg_q   <= sgn_op && a[WIDTH-1];
              dz_q     <= div_op && (b == '0);
`endif
            end
          end
          MDU_CALC: cnt_q <= cnt_q + 6'd1;
          MDU_FIX: begin
            hi_q     <= res_hi;
            lo_q     <= res_lo;
            done_q   <= 1'b1;
`ifdef MDU_DIV_EN
            dz_out_q <= dz_q;
`endif
          end
          default: ;
        endcase
      end
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign done = done_q;
`ifdef MDU_DIV_EN
  assign div_zero = dz_out_q;
`else
  assign div_zero = 1'b0;
`endif

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomized + directed bench for mult_div_unit against an
// arithmetic reference model (honours MDU_DIV_EN).
module tb_mult_div_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        div_zero;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .flush    (flush),
    .hi       (hi),
    .lo       (lo),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // kind: 0 no-op, 1 iterative, 2 MTHI, 3 MTLO
  function automatic void model(input logic [2:0] o,
                                input logic [31:0] xa, xb,
                                output logic [31:0] eh, el,
                                output bit ez, output int kind);
    longint          sp;
    longint unsigned up;
    int              sa, sb;
    sa = xa;
    sb = xb;
    eh = exp_hi;
    el = exp_lo;
    ez = 0;
    kind = 0;
    case (o)
      3'd0: begin
        sp = longint'(sa) * longint'(sb);
        {eh, el} = sp;
        kind = 1;
      end
      3'd1: begin
        up = {32'd0, xa} * {32'd0, xb};
        {eh, el} = up;
        kind = 1;
      end
`ifdef MDU_DIV_EN
      3'd2, 3'd3: begin
        kind = 1;
        if (xb == 0) begin
          el = 32'hFFFF_FFFF;
          eh = xa;
          ez = 1;
        end else if (o == 3'd3) begin
          el = xa / xb;
          eh = xa % xb;
        end else if (xa == 32'h8000_0000 && xb == 32'hFFFF_FFFF) begin
          el = 32'h8000_0000;
          eh = 32'h0;
        end else begin
          el = sa / sb;
          eh = sa % sb;
        end
      end
`endif
      3'd4: begin eh = xa; kind = 2; end
      3'd5: begin el = xa; kind = 3; end
      default: kind = 0;
    endcase
  endfunction

  // intr: 0 none, 1 stray start, 2 flush, 3 reset; at = cycle after E0
  task automatic run_op(input logic [2:0] o, input logic [31:0] xa, xb,
                        input int intr, input int at);
    logic [31:0] eh, el;
    bit ez;
    int kind, lat, ndone, nbusy, dropped;
    model(o, xa, xb, eh, el, ez, kind);
    @(negedge clk);
    start = 1'b1; op = o; a = xa; b = xb;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom;
    if (kind >= 2) begin
      check("mt_done", done, 1);
      check("mt_busy", busy, 0);
      check("mt_hi", hi, eh);
      check("mt_lo", lo, el);
      exp_hi = eh; exp_lo = el;
      @(posedge clk); #1;
      check("mt_done_pulse", done, 0);
      return;
    end
    if (kind == 0) begin
      ndone = 0; nbusy = 0;
      for (int c = 0; c < 40; c++) begin
        if (done) ndone++;
        if (busy) nbusy++;
        @(posedge clk); #1;
      end
      check("noop_done", ndone, 0);
      check("noop_busy", nbusy, 0);
      check("noop_hi", hi, exp_hi);
      check("noop_lo", lo, exp_lo);
      return;
    end
    check("busy_e0", busy, 1);
    lat = 0; dropped = 0;
    for (int c = 1; c <= 40; c++) begin
      if (intr != 0 && c == at) begin
        @(negedge clk);
        case (intr)
          1: begin start = 1'b1; op = 3'd4; a = 32'hDEAD_BEEF; end
          2: flush = 1'b1;
          default: rst_n = 1'b0;
        endcase
        if (intr == 3) begin
          #1;
          check("rst_hi", hi, 0);
          check("rst_lo", lo, 0);
          check("rst_busy", busy, 0);
          check("rst_done", done, 0);
          @(negedge clk);
          rst_n = 1'b1;
          exp_hi = '0; exp_lo = '0;
          return;
        end
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (intr == 2 && c == at) begin
        flush = 1'b0;
        check("flush_busy", busy, 0);
        ndone = 0;
        for (int k = 0; k < 40; k++) begin
          if (done || busy) ndone++;
          @(posedge clk); #1;
        end
        check("flush_no_done", ndone, 0);
        check("flush_hi", hi, exp_hi);
        check("flush_lo", lo, exp_lo);
        return;
      end
      if (done) begin
        lat = c;
        break;
      end
      if (!busy) dropped++;
    end
    check("latency", lat, 33);
    check("busy_held", dropped, 0);
    check("busy_end", busy, 0);
    check("hi", hi, eh);
    check("lo", lo, el);
    check("div_zero", div_zero, ez);
    exp_hi = eh; exp_lo = el;
    @(posedge clk); #1;
    check("done_pulse", done, 0);
    check("dz_pulse", div_zero, 0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst_n = 1'b0; start = 1'b0; op = '0;
    a = '0; b = '0; flush = 1'b0;
    #12;
    check("reset_hi", hi, 0);
    check("reset_lo", lo, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_dz", div_zero, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
    run_op(3'd0, 32'hFFFF_FFFD, 32'd7, 0, 0);
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 0, 0);
    run_op(3'd3, 32'd100, 32'd0, 0, 0);
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    run_op(3'd2, 32'hFFFF_FFF0, 32'd0, 0, 0);
    run_op(3'd4, 32'h1234_5678, 32'd0, 0, 0);
    run_op(3'd5, 32'h9ABC_DEF0, 32'd0, 0, 0);
    run_op(3'd0, 32'd1234, 32'hFFFF_FF00, 1, 5);
    run_op(3'd4, 32'h0BAD_F00D, 32'd0, 0, 0);
    run_op(3'd0, 32'd99, 32'd77, 2, 10);
    run_op(3'd6, 32'd5, 32'd6, 0, 0);
    run_op(3'd2, 32'd10, 32'd3, 0, 0);
    run_op(3'd0, 32'd99, 32'd77, 3, 10);

    for (int i = 0; i < 40; i++)
      run_op(3'($urandom_range(0, 7)), pick(), pick(), 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
